// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-port data-memory arbiter with branch squash (option: DMEM_ARB_ROUND_ROBIN_EN)
module dmem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  input  logic [3:0]  req0_rmask,
  input  logic [3:0]  req0_wmask,
  input  logic [31:0] req0_wdata,
  output logic        req0_gnt,
  output logic        req0_resp,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic [3:0]  req1_rmask,
  input  logic [3:0]  req1_wmask,
  input  logic [31:0] req1_wdata,
  output logic        req1_gnt,
  output logic        req1_resp,
  output logic [31:0] req1_rdata,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        arb_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state;
  logic        owner;      // port of the access in flight (or of the pending zero-mask resp)
  logic        zm_pend;    // zero-mask grant last cycle: respond now, block new grants
  logic        cand0;
  logic        cand1;
  logic        can_grant;
  logic        grant_any;
  logic        winner;
  logic [31:0] sel_addr;
  logic [3:0]  sel_rmask;
  logic [3:0]  sel_wmask;
  logic [31:0] sel_wdata;
  logic        sel_zero;
  logic        busy_resp0;
  logic        busy_resp1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic        rr_ptr;     // port preferred on the next tie
`endif

  // Arbitration: speculative port 0 is masked during a flush; tie broken by RR or fixed priority
  always_comb begin
    cand0     = req0_valid & ~branch;
    cand1     = req1_valid;
    can_grant = rst_n & (state == ST_IDLE) & ~zm_pend;
    grant_any = can_grant & (cand0 | cand1);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    winner    = (cand0 & cand1) ? rr_ptr : cand1;
`else
    winner    = cand1;
`endif
    sel_addr  = winner ? req1_addr  : req0_addr;
    sel_rmask = winner ? req1_rmask : req0_rmask;
    sel_wmask = winner ? req1_wmask : req0_wmask;
    sel_wdata = winner ? req1_wdata : req0_wdata;
    sel_zero  = (sel_rmask == 4'h0) && (sel_wmask == 4'h0);
  end

  // Grant and response pulses; a flush suppresses any port-0 completion in the same cycle
  always_comb begin
    busy_resp0 = (state == ST_BUSY) & dmem_resp & ~owner & ~branch;
    busy_resp1 = (state == ST_BUSY) & dmem_resp & owner;
    req0_gnt   = grant_any & ~winner;
    req1_gnt   = grant_any & winner;
    req0_resp  = busy_resp0 | (zm_pend & ~owner & ~branch);
    req1_resp  = busy_resp1 | (zm_pend & owner);
    req0_rdata = busy_resp0 ? dmem_rdata : 32'h0;
    req1_rdata = busy_resp1 ? dmem_rdata : 32'h0;
    arb_busy   = (state != ST_IDLE);
  end

  // State machine and registered memory-side request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      zm_pend    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_rmask <= 4'h0;
      dmem_wmask <= 4'h0;
      dmem_wdata <= 32'h0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      rr_ptr     <= 1'b0;
`endif
    end else begin
      zm_pend <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            owner <= winner;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_ptr <= ~winner;
`endif
            if (sel_zero) begin
              zm_pend <= 1'b1;
            end else begin
              dmem_addr  <= sel_addr;
              dmem_rmask <= sel_rmask;
              dmem_wmask <= sel_wmask;
              dmem_wdata <= sel_wdata;
              state      <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (dmem_resp) begin
            dmem_addr  <= 32'h0;
            dmem_rmask <= 4'h0;
            dmem_wmask <= 4'h0;
            dmem_wdata <= 32'h0;
            state      <= ST_IDLE;
          end else if (branch && !owner) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (dmem_resp) begin
            dmem_addr  <= 32'h0;
            dmem_rmask <= 4'h0;
            dmem_wmask <= 4'h0;
            dmem_wdata <= 32'h0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          dmem_addr  <= 32'h0;
          dmem_rmask <= 4'h0;
          dmem_wmask <= 4'h0;
          dmem_wdata <= 32'h0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_addr = '0;
  logic [3:0]  req0_rmask = '0;
  logic [3:0]  req0_wmask = '0;
  logic [31:0] req0_wdata = '0;
  logic        req0_gnt;
  logic        req0_resp;
  logic [31:0] req0_rdata;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_addr = '0;
  logic [3:0]  req1_rmask = '0;
  logic [3:0]  req1_wmask = '0;
  logic [31:0] req1_wdata = '0;
  logic        req1_gnt;
  logic        req1_resp;
  logic [31:0] req1_rdata;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_resp = 1'b0;
  logic        arb_busy;

  int n_checks = 0;
  int n_fail = 0;

  dmem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .branch(branch),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_rmask(req0_rmask),
    .req0_wmask(req0_wmask), .req0_wdata(req0_wdata), .req0_gnt(req0_gnt),
    .req0_resp(req0_resp), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_rmask(req1_rmask),
    .req1_wmask(req1_wmask), .req1_wdata(req1_wdata), .req1_gnt(req1_gnt),
    .req1_resp(req1_resp), .req1_rdata(req1_rdata),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic quiet();
    branch = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    dmem_resp = 1'b0; dmem_rdata = '0;
  endtask

  task automatic do_reset();
    step(); rst_n = 1'b0; quiet();
    step(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [109:0] all_out;
    step(); quiet(); #1;
    all_out = {req0_gnt, req0_resp, req0_rdata, req1_gnt, req1_resp, req1_rdata,
               dmem_addr[7:0], dmem_rmask, dmem_wmask, arb_busy, 24'h0, 8'h0};
    n_checks++;
    if (all_out !== '0 || dmem_addr !== 0 || dmem_wdata !== 0) begin
      n_fail++; $display("FAIL reset_initial: outputs not all zero (busy=%0b addr=%h)", arb_busy, dmem_addr);
    end
    step(); rst_n = 1'b1;
    step(); req0_valid = 1'b1; req0_addr = 32'h40; req0_rmask = 4'hF; req0_wmask = 4'h0;
    step(); req0_valid = 1'b0; #1;
    n_checks++;
    if (dmem_rmask !== 4'hF || arb_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_busy: rmask=%h busy=%0b, want rmask=f busy=1", dmem_rmask, arb_busy);
    end
    step(); rst_n = 1'b0; #1;
    n_checks++;
    if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, arb_busy, req0_resp, req1_resp,
         req0_gnt, req1_gnt, req0_rdata, req1_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_mid_busy: addr=%h rmask=%h busy=%0b, want all 0", dmem_addr, dmem_rmask, arb_busy);
    end
    step(); rst_n = 1'b1;
  endtask

  task automatic test_single_load();
    step(); req0_valid = 1'b1; req0_addr = 32'h100; req0_rmask = 4'hF; req0_wmask = 4'h0; #1;
    n_checks++;
    if ({req0_gnt, req1_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL load_gnt: gnt0/1=%b%b want 10", req0_gnt, req1_gnt);
    end
    for (int i = 1; i <= 3; i++) begin
      step(); req0_valid = 1'b0;
      if (i == 3) begin dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      #1;
      n_checks++;
      if (dmem_addr !== 32'h100 || dmem_rmask !== 4'hF || dmem_wmask !== 4'h0) begin
        n_fail++; $display("FAIL load_hold_t%0d: addr=%h rmask=%h want 100/f", i, dmem_addr, dmem_rmask);
      end
      n_checks++;
      if (req0_resp !== (i == 3) || req1_resp !== 1'b0) begin
        n_fail++; $display("FAIL load_resp_t%0d: resp0=%b resp1=%b want %0d/0", i, req0_resp, req1_resp, i == 3);
      end
    end
    n_checks++;
    if (req0_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_rdata: got %h want deadbeef", req0_rdata);
    end
    step(); quiet(); #1;
    n_checks++;
    if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, arb_busy} !== '0) begin
      n_fail++; $display("FAIL load_clear: addr=%h rmask=%h busy=%b want 0", dmem_addr, dmem_rmask, arb_busy);
    end
  endtask

  task automatic test_tie();
    logic exp_port;
    do_reset();
    for (int r = 0; r < 4; r++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_port = r[0];
`else
      exp_port = 1'b1;
`endif
      step();
      req0_valid = 1'b1; req0_addr = 32'h500 + r*4; req0_rmask = 4'hF; req0_wmask = 4'h0;
      req1_valid = 1'b1; req1_addr = 32'h600 + r*4; req1_rmask = 4'h0; req1_wmask = 4'h3;
      req1_wdata = 32'h1234_0000 + r;
      #1;
      n_checks++;
      if ({req1_gnt, req0_gnt} !== (exp_port ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL tie_round%0d: gnt1/0=%b%b want port %0d", r, req1_gnt, req0_gnt, exp_port);
      end
      step(); quiet(); dmem_resp = 1'b1; #1;
      n_checks++;
      if (dmem_addr !== (exp_port ? 32'h600 + r*4 : 32'h500 + r*4)) begin
        n_fail++; $display("FAIL tie_addr%0d: addr=%h", r, dmem_addr);
      end
      step(); quiet();
    end
  endtask

  task automatic test_flush();
    step(); req0_valid = 1'b1; req0_addr = 32'h200; req0_rmask = 4'hF; req0_wmask = 4'h0;
    step(); req0_valid = 1'b0; branch = 1'b1; #1;
    n_checks++;
    if (req0_resp !== 1'b0 || dmem_rmask !== 4'hF) begin
      n_fail++; $display("FAIL flush_busy: resp0=%b rmask=%h want 0/f", req0_resp, dmem_rmask);
    end
    for (int i = 0; i < 2; i++) begin
      step(); branch = 1'b0; #1;
      n_checks++;
      if (dmem_rmask !== 4'hF || dmem_addr !== 32'h200 || arb_busy !== 1'b1) begin
        n_fail++; $display("FAIL flush_drain_hold%0d: rmask=%h addr=%h busy=%b", i, dmem_rmask, dmem_addr, arb_busy);
      end
    end
    step(); dmem_resp = 1'b1; dmem_rdata = 32'hCAFEF00D; #1;
    n_checks++;
    if (req0_resp !== 1'b0 || req1_resp !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_resp: resp0=%b resp1=%b want 0/0", req0_resp, req1_resp);
    end
    step(); quiet(); #1;
    n_checks++;
    if (arb_busy !== 1'b0 || dmem_rmask !== 4'h0) begin
      n_fail++; $display("FAIL flush_idle: busy=%b rmask=%h want 0/0", arb_busy, dmem_rmask);
    end
  endtask

  task automatic test_flush_store();
    step(); req1_valid = 1'b1; req1_addr = 32'h300; req1_rmask = 4'h0; req1_wmask = 4'hF;
    req1_wdata = 32'hA5A5_5A5A;
    step(); req1_valid = 1'b0; branch = 1'b1; #1;
    n_checks++;
    if (dmem_wmask !== 4'hF || dmem_wdata !== 32'hA5A5_5A5A || req1_resp !== 1'b0) begin
      n_fail++; $display("FAIL store_hold: wmask=%h wdata=%h resp1=%b", dmem_wmask, dmem_wdata, req1_resp);
    end
    step(); dmem_resp = 1'b1; #1;
    n_checks++;
    if (req1_resp !== 1'b1 || req0_resp !== 1'b0) begin
      n_fail++; $display("FAIL store_flush_resp: resp1=%b resp0=%b want 1/0", req1_resp, req0_resp);
    end
    step(); quiet(); #1;
    n_checks++;
    if (arb_busy !== 1'b0 || dmem_wmask !== 4'h0) begin
      n_fail++; $display("FAIL store_idle: busy=%b wmask=%h want 0/0", arb_busy, dmem_wmask);
    end
  endtask

  task automatic test_zero_mask();
    step(); req0_valid = 1'b1; req0_addr = 32'h700; req0_rmask = 4'h0; req0_wmask = 4'h0; #1;
    n_checks++;
    if (req0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL zm_gnt: gnt0=%b want 1", req0_gnt);
    end
    step(); req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 32'h704; req1_rmask = 4'h0; req1_wmask = 4'h0; #1;
    n_checks++;
    if (req0_resp !== 1'b1 || req0_rdata !== 32'h0 || req1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL zm_resp: resp0=%b rdata0=%h gnt1=%b want 1/0/0", req0_resp, req0_rdata, req1_gnt);
    end
    n_checks++;
    if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, arb_busy} !== '0) begin
      n_fail++; $display("FAIL zm_no_access: addr=%h busy=%b want 0", dmem_addr, arb_busy);
    end
    step(); #1;
    n_checks++;
    if (req1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL zm_next_gnt: gnt1=%b want 1", req1_gnt);
    end
    step(); quiet(); #1;
    n_checks++;
    if (req1_resp !== 1'b1) begin
      n_fail++; $display("FAIL zm_resp1: resp1=%b want 1", req1_resp);
    end
    step(); req0_valid = 1'b1; req0_rmask = 4'h0; req0_wmask = 4'h0;
    step(); req0_valid = 1'b0; branch = 1'b1; #1;
    n_checks++;
    if (req0_resp !== 1'b0) begin
      n_fail++; $display("FAIL zm_flush: resp0=%b want 0", req0_resp);
    end
    step(); quiet();
  endtask

  // Random transactions against a transaction-level model of the arbitration rules.
  task automatic test_random();
    logic        ptr_m;
    logic        v[2];
    logic [31:0] a[2];
    logic [3:0]  rm[2];
    logic [3:0]  wm[2];
    logic [31:0] wd[2];
    logic        bv, c0, c1, w, br2, exp_resp;
    int          lat, fl, kind;
    logic [31:0] rd;
    do_reset();
    ptr_m = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        v[p]  = ($urandom % 4) != 0;
        a[p]  = {$urandom, 2'b00} & 32'hFFFF_FFFC;
        wd[p] = $urandom;
        kind  = $urandom % 3;
        rm[p] = (kind == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        wm[p] = (kind == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      bv = ($urandom % 5) == 0;
      c0 = v[0] & ~bv;
      c1 = v[1];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      w  = (c0 && c1) ? ptr_m : c1;
`else
      w  = c1;
`endif
      step();
      branch = bv;
      req0_valid = v[0]; req0_addr = a[0]; req0_rmask = rm[0]; req0_wmask = wm[0]; req0_wdata = wd[0];
      req1_valid = v[1]; req1_addr = a[1]; req1_rmask = rm[1]; req1_wmask = wm[1]; req1_wdata = wd[1];
      #1;
      n_checks++;
      if ({req1_gnt, req0_gnt} !== (!(c0 || c1) ? 2'b00 : (w ? 2'b10 : 2'b01))) begin
        n_fail++; $display("FAIL rnd_gnt it%0d: gnt1/0=%b%b v=%b%b br=%b", it, req1_gnt, req0_gnt, v[1], v[0], bv);
      end
      if (!(c0 || c1)) begin
        step(); quiet();
        continue;
      end
      ptr_m = ~w;
      if (rm[w] == 4'h0 && wm[w] == 4'h0) begin
        br2 = $urandom % 2;
        step(); quiet(); branch = br2; #1;
        exp_resp = !(w == 1'b0 && br2);
        n_checks++;
        if ({req1_resp, req0_resp} !== (exp_resp ? (w ? 2'b10 : 2'b01) : 2'b00) ||
            req0_rdata !== 0 || req1_rdata !== 0 || dmem_rmask !== 0 || dmem_wmask !== 0) begin
          n_fail++; $display("FAIL rnd_zm it%0d: resp1/0=%b%b port=%0d br=%b", it, req1_resp, req0_resp, w, br2);
        end
        step(); quiet();
        continue;
      end
      fl  = (w == 1'b0) ? int'($urandom % 3) : int'($urandom % 2);
      lat = $urandom_range(1, 3);
      for (int i = 0; i < lat; i++) begin
        step(); quiet(); branch = (fl == 1 && i == 0); #1;
        n_checks++;
        if (dmem_addr !== a[w] || dmem_rmask !== rm[w] || dmem_wmask !== wm[w] || dmem_wdata !== wd[w] ||
            arb_busy !== 1'b1 || req0_resp !== 1'b0 || req1_resp !== 1'b0) begin
          n_fail++; $display("FAIL rnd_hold it%0d: addr=%h want %h rm=%h want %h wm=%h want %h", it,
                             dmem_addr, a[w], dmem_rmask, rm[w], dmem_wmask, wm[w]);
        end
      end
      rd = $urandom;
      step(); quiet(); dmem_resp = 1'b1; dmem_rdata = rd; branch = (fl == 2); #1;
      exp_resp = !(w == 1'b0 && fl != 0);
      n_checks++;
      if ({req1_resp, req0_resp} !== (exp_resp ? (w ? 2'b10 : 2'b01) : 2'b00) ||
          (w ? req1_rdata : req0_rdata) !== (exp_resp ? rd : 32'h0)) begin
        n_fail++; $display("FAIL rnd_resp it%0d: resp1/0=%b%b port=%0d fl=%0d rdata0=%h rdata1=%h want %h",
                           it, req1_resp, req0_resp, w, fl, req0_rdata, req1_rdata, rd);
      end
      step(); quiet(); #1;
      n_checks++;
      if (arb_busy !== 1'b0 || dmem_addr !== 0 || dmem_rmask !== 0 || dmem_wmask !== 0 || dmem_wdata !== 0) begin
        n_fail++; $display("FAIL rnd_clear it%0d: busy=%b addr=%h", it, arb_busy, dmem_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_tie();
    test_flush();
    test_flush_store();
    test_zero_mask();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
